// File: rtl/l1dcache_core_responder_pkg.sv
// Shared types and address-split helpers for the direct-mapped L1 data cache.
package l1dcache_core_responder_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
  } mem_req_t;

  function automatic int offsetWidth(input int wordsPerLine);
    return $clog2(wordsPerLine);
  endfunction

  function automatic int indexWidth(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagWidth(input int sets, input int wordsPerLine);
    return ADDR_W - $clog2(sets) - $clog2(wordsPerLine);
  endfunction

endpackage

// File: rtl/l1dcache_core_responder_if.sv
// Memory-stage to L1 data cache request/response interface.
interface l1dcache_core_if;
  import l1dcache_core_responder_pkg::*;

  logic              en;
  logic              enW;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] reqData;
  logic [MASK_W-1:0] mask;
  logic              kill;
  logic              hit;
  logic [DATA_W-1:0] respData;

  modport master (output en, enW, addr, reqData, mask, kill, input hit, respData);
  modport slave  (input en, enW, addr, reqData, mask, kill, output hit, respData);
endinterface

// File: rtl/l1dcache_core_responder_array.sv
// Tag, valid and data storage: synchronous read, byte-masked word write,
// valid bits cleared asynchronously by reset.
module l1dcache_array
  import l1dcache_core_responder_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int WPL   = 4,
  parameter int IDX_W = 6,
  parameter int OFF_W = 2,
  parameter int TAG_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdEn_i,
  input  logic [IDX_W-1:0]  rdIdx_i,
  input  logic [OFF_W-1:0]  rdOff_i,
  output logic              rdValid_o,
  output logic [TAG_W-1:0]  rdTag_o,
  output logic [DATA_W-1:0] rdData_o,
  input  logic              wrEn_i,
  input  logic [IDX_W-1:0]  wrIdx_i,
  input  logic [OFF_W-1:0]  wrOff_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic [MASK_W-1:0] wrMask_i,
  input  logic              tagWe_i,
  input  logic [TAG_W-1:0]  tagData_i
);

  logic [TAG_W-1:0]  tagMem  [SETS];
  logic [DATA_W-1:0] dataMem [SETS*WPL];
  logic [SETS-1:0]   valid_q;
  logic              rdValid_q;
  logic [TAG_W-1:0]  rdTag_q;
  logic [DATA_W-1:0] rdData_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      rdValid_q <= 1'b0;
    end else begin
      if (tagWe_i) valid_q[wrIdx_i] <= 1'b1;
      if (rdEn_i)  rdValid_q <= valid_q[rdIdx_i];
    end
  end

  // Storage arrays are deliberately left unreset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (rdEn_i) begin
      rdTag_q  <= tagMem[rdIdx_i];
      rdData_q <= dataMem[{rdIdx_i, rdOff_i}];
    end
    if (tagWe_i) tagMem[wrIdx_i] <= tagData_i;
    if (wrEn_i) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (wrMask_i[b]) dataMem[{wrIdx_i, wrOff_i}][8*b +: 8] <= wrData_i[8*b +: 8];
      end
    end
  end

  assign rdValid_o = rdValid_q;
  assign rdTag_o   = rdTag_q;
  assign rdData_o  = rdData_q;

endmodule

// File: rtl/l1dcache_core_responder.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache responder.
// Optional hit/miss counters are built when L1DCACHE_STATS_EN is defined.
module l1dcache_core_responder
  import l1dcache_core_responder_pkg::*;
#(
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst,
  l1dcache_core_if.slave    cache,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_mask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef L1DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int OFF_W = offsetWidth(WORDS_PER_LINE);
  localparam int IDX_W = indexWidth(SETS);
  localparam int TAG_W = tagWidth(SETS, WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_t            state_q, state_d;
  logic              reqValid_q, reqValid_d;
  logic              reqWe_q, reqWe_d;
  logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
  logic [DATA_W-1:0] reqData_q, reqData_d;
  logic [MASK_W-1:0] reqMask_q, reqMask_d;
  logic              memReq_q, memReq_d;
  mem_req_t          memBus_q, memBus_d;
  logic [OFF_W-1:0]  beat_q, beat_d;

  logic              rdValid;
  logic [TAG_W-1:0]  rdTag;
  logic [DATA_W-1:0] rdData;
  logic              wrEn, tagWe;
  logic [IDX_W-1:0]  wrIdx;
  logic [OFF_W-1:0]  wrOff;
  logic [DATA_W-1:0] wrData;
  logic [MASK_W-1:0] wrMask;
  logic [TAG_W-1:0]  tagData;

  logic tagMatch, loadHit, loadMiss, storeGo, capture;

  assign tagMatch = rdValid && (rdTag == reqAddr_q[ADDR_W-1 -: TAG_W]);
  assign loadHit  = reqValid_q && !reqWe_q && tagMatch;
  assign loadMiss = reqValid_q && !reqWe_q && !tagMatch;
  assign storeGo  = reqValid_q && reqWe_q && !cache.kill;
  // A request arriving while the previous one is about to leave IDLE is dropped.
  assign capture  = cache.en && (state_q == IDLE) && !loadMiss && !storeGo;

  assign cache.hit      = loadHit || storeGo;
  assign cache.respData = loadHit ? rdData : '0;

  l1dcache_array #(
    .SETS (SETS),
    .WPL  (WORDS_PER_LINE),
    .IDX_W(IDX_W),
    .OFF_W(OFF_W),
    .TAG_W(TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rdEn_i   (capture),
    .rdIdx_i  (cache.addr[OFF_W +: IDX_W]),
    .rdOff_i  (cache.addr[OFF_W-1:0]),
    .rdValid_o(rdValid),
    .rdTag_o  (rdTag),
    .rdData_o (rdData),
    .wrEn_i   (wrEn),
    .wrIdx_i  (wrIdx),
    .wrOff_i  (wrOff),
    .wrData_i (wrData),
    .wrMask_i (wrMask),
    .tagWe_i  (tagWe),
    .tagData_i(tagData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      reqValid_q <= 1'b0;
      reqWe_q    <= 1'b0;
      reqAddr_q  <= '0;
      reqData_q  <= '0;
      reqMask_q  <= '0;
      memReq_q   <= 1'b0;
      memBus_q   <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      reqValid_q <= reqValid_d;
      reqWe_q    <= reqWe_d;
      reqAddr_q  <= reqAddr_d;
      reqData_q  <= reqData_d;
      reqMask_q  <= reqMask_d;
      memReq_q   <= memReq_d;
      memBus_q   <= memBus_d;
      beat_q     <= beat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    reqValid_d = capture;
    reqWe_d    = capture ? cache.enW     : reqWe_q;
    reqAddr_d  = capture ? cache.addr    : reqAddr_q;
    reqData_d  = capture ? cache.reqData : reqData_q;
    reqMask_d  = capture ? cache.mask    : reqMask_q;
    memReq_d   = memReq_q;
    memBus_d   = memBus_q;
    beat_d     = beat_q;
    wrEn       = 1'b0;
    wrIdx      = reqAddr_q[OFF_W +: IDX_W];
    wrOff      = reqAddr_q[OFF_W-1:0];
    wrData     = reqData_q;
    wrMask     = reqMask_q;
    tagWe      = 1'b0;
    tagData    = memBus_q.addr[ADDR_W-1 -: TAG_W];

    unique case (state_q)
      IDLE: begin
        if (loadMiss) begin
          state_d  = REFILL;
          memReq_d = 1'b1;
          memBus_d = '{we: 1'b0, addr: {reqAddr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}},
                       wdata: '0, mask: '1};
          beat_d   = '0;
        end else if (storeGo) begin
          wrEn     = tagMatch;
          state_d  = WRITE;
          memReq_d = 1'b1;
          memBus_d = '{we: 1'b1, addr: reqAddr_q, wdata: reqData_q, mask: reqMask_q};
        end
      end
      REFILL: begin
        if (mem_ack) begin
          wrEn   = 1'b1;
          wrIdx  = memBus_q.addr[OFF_W +: IDX_W];
          wrOff  = beat_q;
          wrData = mem_rdata;
          wrMask = '1;
          if (beat_q == LAST_BEAT) begin
            tagWe    = 1'b1;
            state_d  = IDLE;
            memReq_d = 1'b0;
          end else begin
            beat_d        = beat_q + OFF_W'(1);
            memBus_d.addr = memBus_q.addr + ADDR_W'(1);
          end
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_d     = IDLE;
          memReq_d    = 1'b0;
          memBus_d.we = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = memReq_q;
  assign mem_we    = memBus_q.we;
  assign mem_addr  = memBus_q.addr;
  assign mem_wdata = memBus_q.wdata;
  assign mem_mask  = memBus_q.mask;

`ifdef L1DCACHE_STATS_EN
  logic [31:0] statHits_q, statMisses_q;

  // Counters saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statHits_q   <= '0;
      statMisses_q <= '0;
    end else begin
      if (loadHit && (statHits_q != '1))    statHits_q   <= statHits_q + 32'd1;
      if (loadMiss && (statMisses_q != '1)) statMisses_q <= statMisses_q + 32'd1;
    end
  end

  assign stat_hits   = statHits_q;
  assign stat_misses = statMisses_q;
`endif

endmodule

// File: doc/l1dcache_core_responder.md
Name: l1dcache_core_responder

Overview:
- Responder end of l1dcache_core_if: a direct-mapped, write-through, no-write-allocate L1 data cache serving the memory stage.
- Accepts one word-granular request per cycle and returns hit/respData one cycle later.
- Refills lines on load misses and forwards every committed store to a simple single-beat backing-memory bus.

Parameters:
- SETS, 64, number of lines; power of two, >=2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, >=2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cache.en  in  1  request valid, cycle N.
- cache.enW  in  1  request is a store, cycle N.
- cache.addr  in  30  word address, cycle N.
- cache.reqData  in  32  store data, cycle N.
- cache.mask  in  4  byte enables, cycle N.
- cache.kill  in  1  cycle N+1: cancel the pending store.
- cache.hit  out  1  cycle N+1: request serviced.
- cache.respData  out  32  cycle N+1: load data.
- mem_req  out  1  bus request; held until mem_ack.
- mem_we  out  1  bus write.
- mem_addr  out  30  bus word address.
- mem_wdata  out  32  bus write data.
- mem_mask  out  4  bus byte enables.
- mem_ack  in  1  beat complete; mem_rdata valid the same cycle.
- mem_rdata  in  32  bus read data.

Behaviour:
- Address split: offset = addr[log2(WPL)-1:0], index = next log2(SETS) bits, tag = the remaining bits.
- Reset (async): all valid bits 0; FSM = IDLE; hit 0; respData 0; mem_req 0; mem_we 0; mem_addr 0; mem_wdata 0; mem_mask 0. Data and tag arrays are not reset.
- Request capture: at the posedge ending cycle N with en=1 and FSM=IDLE, register the request and read the arrays. In N+1: hit = valid[idx] && tag match && FSM==IDLE-at-capture; respData = the stored word for loads, 0 otherwise.
- Requests arriving while FSM != IDLE are not captured; hit=0 in N+1 and the client retries.
- Load hit: hit=1, respData valid in N+1. No state change.
- Load miss: hit=0. The FSM goes IDLE->REFILL.
  - REFILL issues WPL reads starting at offset 0 of the line, one outstanding at a time.
  - Each mem_ack writes that word to the data array.
  - After the last ack: write the tag, set valid, return to IDLE.
  - If a load is killed, the refill still completes.
- Store, kill=0 in N+1:
  - If the tag matches, merge the masked bytes into the line and hit=1. If it does not match, no allocate and hit=1 (the store is accepted).
  - Either way go to WRITE: mem_req=1, mem_we=1, registered addr/data/mask; held stable until mem_ack, then IDLE.
- Store, kill=1 in N+1: no array update, no bus write, hit=0, stay IDLE.
- kill on a load: no effect except the refill rule above.
- Only one bus transaction is outstanding at a time. mem_req is driven only from the REFILL or WRITE states.
- A request in the first cycle after returning to IDLE is accepted normally. A refilled line is immediately hittable.
- Reset mid-REFILL or mid-WRITE: the FSM returns to IDLE at once, mem_req drops, and the partial line stays invalid.

Optional Feature:
- L1DCACHE_STATS_EN defined: add outputs stat_hits (32, out) and stat_misses (32, out).
  - stat_hits counts load hits. stat_misses counts load misses, including misses that cause a refill.
  - Both counters saturate at 2^32-1 and reset to 0.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package L1dCache holds:
  - the state_t enum {IDLE, REFILL, WRITE};
  - tag/index/offset width functions;
  - the mem_req_t struct (we, addr, wdata, mask).
- The shared mask/size encodings stay in Uop.
- One natural sub-module: l1dcache_array (tag, valid and data storage; sync read; byte-masked write; async valid clear).

Test Plan:
1. After reset, load addr 0x40 -> N+1 hit=0. The bus reads 0x40..0x43 (acks return 0xA0..0xA3). The same load is then retried -> hit=1, respData=0xA0.
2. Resident line, store addr 0x41, mask 0b0011, data 0x1234BEEF, kill=0 -> hit=1, one bus write (0x41, 0x1234BEEF, 0b0011). A later load 0x41 -> respData=0xA1A1BEEF (given stored 0xA1A1A1A1).
3. Store with kill=1 in N+1 -> mem_req stays 0 and a later load returns the old data.
4. Request during REFILL -> hit=0, no capture. The refill completes and the retry hits.
5. Store to a non-resident addr 0x200 -> bus write issued, hit=1. A subsequent load of 0x200 misses, proving no allocate.
6. Assert rst during the 2nd refill beat -> mem_req=0 immediately. A reload of the same address misses and refills all 4 words.
